// File: rtl/aes_avalon_interface.sv
// Avalon-MM slave wrapper around the AES decryption core: key/ciphertext registers,
// start/done handshake, plaintext capture and a saturating run-cycle counter.
module aes_avalon_interface #(
    parameter int CNT_W = 32
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         AVL_CS,
    input  logic         AVL_READ,
    input  logic         AVL_WRITE,
    input  logic [3:0]   AVL_ADDR,
    input  logic [3:0]   AVL_BYTE_EN,
    input  logic [31:0]  AVL_WRITEDATA,
    output logic [31:0]  AVL_READDATA,
    output logic         AES_START,
    input  logic         AES_DONE,
    output logic [127:0] AES_KEY,
    output logic [127:0] AES_MSG_ENC,
    input  logic [127:0] AES_MSG_DEC,
    output logic [31:0]  EXPORT_DATA
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [31:0]      key_reg     [4];
    logic [31:0]      msg_enc_reg [4];
    logic [31:0]      msg_dec_reg [4];
    logic [CNT_W-1:0] run_cycles;
    logic [31:0]      cycles_ext;

    logic wr_en;
    logic start_wr;
    logic start_set;
    logic start_clr;
    logic start_bit;
    logic done_bit;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] result;
        result = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                result[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return result;
    endfunction

    assign wr_en     = AVL_CS & AVL_WRITE;
    assign start_wr  = wr_en && (AVL_ADDR == 4'd14) && AVL_BYTE_EN[0];
    assign start_set = start_wr & AVL_WRITEDATA[0];
    assign start_clr = start_wr & ~AVL_WRITEDATA[0];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Abort (START written to 0) wins over a simultaneous AES_DONE.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start_set) next_state = ST_RUN;
            ST_RUN: begin
                if (start_clr) begin
                    next_state = ST_IDLE;
                end else if (AES_DONE) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: if (start_clr) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        start_bit = 1'b0;
        done_bit  = 1'b0;
        case (state)
            ST_RUN:  start_bit = 1'b1;
            ST_DONE: begin
                start_bit = 1'b1;
                done_bit  = 1'b1;
            end
            default: begin
                start_bit = 1'b0;
                done_bit  = 1'b0;
            end
        endcase
    end

    assign AES_START = start_bit;

    // The counter advances on every edge the FSM spends in RUN, including the capture edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 4; i++) begin
                key_reg[i]     <= '0;
                msg_enc_reg[i] <= '0;
                msg_dec_reg[i] <= '0;
            end
            run_cycles <= '0;
        end else begin
            if (wr_en && !AVL_ADDR[3] && (state != ST_RUN)) begin
                if (AVL_ADDR[2]) begin
                    msg_enc_reg[AVL_ADDR[1:0]] <= merge_bytes(msg_enc_reg[AVL_ADDR[1:0]],
                                                              AVL_WRITEDATA, AVL_BYTE_EN);
                end else begin
                    key_reg[AVL_ADDR[1:0]] <= merge_bytes(key_reg[AVL_ADDR[1:0]],
                                                          AVL_WRITEDATA, AVL_BYTE_EN);
                end
            end

            if ((state == ST_IDLE) && start_set) begin
                run_cycles <= '0;
            end else if ((state == ST_RUN) && (run_cycles != {CNT_W{1'b1}})) begin
                run_cycles <= run_cycles + 1'b1;
            end

            if ((state == ST_RUN) && !start_clr && AES_DONE) begin
                msg_dec_reg[0] <= AES_MSG_DEC[127:96];
                msg_dec_reg[1] <= AES_MSG_DEC[95:64];
                msg_dec_reg[2] <= AES_MSG_DEC[63:32];
                msg_dec_reg[3] <= AES_MSG_DEC[31:0];
            end
        end
    end

    always_comb begin
        cycles_ext = '0;
        cycles_ext[CNT_W-1:0] = run_cycles;
    end

    always_comb begin
        AVL_READDATA = '0;
        if (AVL_CS && AVL_READ) begin
            case (AVL_ADDR[3:2])
                2'd0: AVL_READDATA = key_reg[AVL_ADDR[1:0]];
                2'd1: AVL_READDATA = msg_enc_reg[AVL_ADDR[1:0]];
                2'd2: AVL_READDATA = msg_dec_reg[AVL_ADDR[1:0]];
                default: begin
                    case (AVL_ADDR[1:0])
                        2'd0:    AVL_READDATA = cycles_ext;
                        2'd2:    AVL_READDATA = {31'd0, start_bit};
                        2'd3:    AVL_READDATA = {31'd0, done_bit};
                        default: AVL_READDATA = '0;
                    endcase
                end
            endcase
        end
    end

    assign AES_KEY     = {key_reg[0], key_reg[1], key_reg[2], key_reg[3]};
    assign AES_MSG_ENC = {msg_enc_reg[0], msg_enc_reg[1], msg_enc_reg[2], msg_enc_reg[3]};
    assign EXPORT_DATA = {key_reg[0][31:16], key_reg[3][15:0]};

endmodule

// File: tb/tb_aes_avalon_interface.sv
// Directed bench for aes_avalon_interface: register table plus handshake, abort,
// reset and counter-saturation sequences (second instance with a 4-bit counter).
module tb_aes_avalon_interface;

    logic         CLK;
    logic         RESET;
    logic         AVL_CS;
    logic         AVL_READ;
    logic         AVL_WRITE;
    logic [3:0]   AVL_ADDR;
    logic [3:0]   AVL_BYTE_EN;
    logic [31:0]  AVL_WRITEDATA;
    logic [31:0]  AVL_READDATA;
    logic         AES_START;
    logic         AES_DONE;
    logic [127:0] AES_KEY;
    logic [127:0] AES_MSG_ENC;
    logic [127:0] AES_MSG_DEC;
    logic [31:0]  EXPORT_DATA;

    logic [31:0]  small_readdata;
    logic         small_start;
    logic [127:0] small_key;
    logic [127:0] small_msg_enc;
    logic [31:0]  small_export;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] PLAIN   = 128'h3243F6A8885A308D313198A2E0370734;
    localparam logic [127:0] CIPHER  = 128'h3925841D02DC09FBDC118597196A0B32;
    localparam logic [127:0] KEY_A   = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [127:0] KEY_B   = 128'h2B7E151628AEFFA6ABF7158801020304;

    aes_avalon_interface #(.CNT_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .AVL_CS(AVL_CS), .AVL_READ(AVL_READ),
        .AVL_WRITE(AVL_WRITE), .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN),
        .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
        .AES_START(AES_START), .AES_DONE(AES_DONE), .AES_KEY(AES_KEY),
        .AES_MSG_ENC(AES_MSG_ENC), .AES_MSG_DEC(AES_MSG_DEC), .EXPORT_DATA(EXPORT_DATA)
    );

    aes_avalon_interface #(.CNT_W(4)) dut_small (
        .CLK(CLK), .RESET(RESET), .AVL_CS(AVL_CS), .AVL_READ(AVL_READ),
        .AVL_WRITE(AVL_WRITE), .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN),
        .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(small_readdata),
        .AES_START(small_start), .AES_DONE(AES_DONE), .AES_KEY(small_key),
        .AES_MSG_ENC(small_msg_enc), .AES_MSG_DEC(AES_MSG_DEC), .EXPORT_DATA(small_export)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [24];

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] addr, input logic [3:0] be,
                                 input logic [31:0] data);
        @(negedge CLK);
        AVL_CS        = 1'b1;
        AVL_WRITE     = 1'b1;
        AVL_ADDR      = addr;
        AVL_BYTE_EN   = be;
        AVL_WRITEDATA = data;
        @(posedge CLK);
        #1;
        AVL_CS    = 1'b0;
        AVL_WRITE = 1'b0;
    endtask

    task automatic readReg(input logic [3:0] addr, output logic [31:0] d,
                           output logic [31:0] ds);
        @(negedge CLK);
        AVL_CS   = 1'b1;
        AVL_READ = 1'b1;
        AVL_ADDR = addr;
        #1;
        d  = AVL_READDATA;
        ds = small_readdata;
        AVL_CS   = 1'b0;
        AVL_READ = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] rds;

        vecs[0]  = '{1'b1, 4'd0,  4'hF, 32'h2B7E1516, 32'h0};
        vecs[1]  = '{1'b1, 4'd1,  4'hF, 32'h28AED2A6, 32'h0};
        vecs[2]  = '{1'b1, 4'd2,  4'hF, 32'hABF71588, 32'h0};
        vecs[3]  = '{1'b1, 4'd3,  4'hF, 32'h09CF4F3C, 32'h0};
        vecs[4]  = '{1'b1, 4'd4,  4'hF, 32'h3925841D, 32'h0};
        vecs[5]  = '{1'b1, 4'd5,  4'hF, 32'h02DC09FB, 32'h0};
        vecs[6]  = '{1'b1, 4'd6,  4'hF, 32'hDC118597, 32'h0};
        vecs[7]  = '{1'b1, 4'd7,  4'hF, 32'h196A0B32, 32'h0};
        vecs[8]  = '{1'b1, 4'd1,  4'h2, 32'hFFFFFFFF, 32'h0};
        vecs[9]  = '{1'b1, 4'd8,  4'hF, 32'h12345678, 32'h0};
        vecs[10] = '{1'b1, 4'd12, 4'hF, 32'h00000055, 32'h0};
        vecs[11] = '{1'b1, 4'd15, 4'hF, 32'h00000001, 32'h0};
        vecs[12] = '{1'b1, 4'd14, 4'hE, 32'h00000001, 32'h0};
        vecs[13] = '{1'b1, 4'd13, 4'hF, 32'hFFFFFFFF, 32'h0};
        vecs[14] = '{1'b0, 4'd1,  4'h0, 32'h0, 32'h28AEFFA6};
        vecs[15] = '{1'b0, 4'd0,  4'h0, 32'h0, 32'h2B7E1516};
        vecs[16] = '{1'b0, 4'd3,  4'h0, 32'h0, 32'h09CF4F3C};
        vecs[17] = '{1'b0, 4'd4,  4'h0, 32'h0, 32'h3925841D};
        vecs[18] = '{1'b0, 4'd7,  4'h0, 32'h0, 32'h196A0B32};
        vecs[19] = '{1'b0, 4'd8,  4'h0, 32'h0, 32'h00000000};
        vecs[20] = '{1'b0, 4'd12, 4'h0, 32'h0, 32'h00000000};
        vecs[21] = '{1'b0, 4'd13, 4'h0, 32'h0, 32'h00000000};
        vecs[22] = '{1'b0, 4'd14, 4'h0, 32'h0, 32'h00000000};
        vecs[23] = '{1'b0, 4'd15, 4'h0, 32'h0, 32'h00000000};

        RESET = 1'b1; AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
        AVL_ADDR = '0; AVL_BYTE_EN = '0; AVL_WRITEDATA = '0;
        AES_DONE = 1'b0; AES_MSG_DEC = PLAIN;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;

        $display("[TB] reset state");
        for (int a = 0; a < 16; a++) begin
            readReg(a[3:0], rd, rds);
            checkOutput($sformatf("reset_rd%0d", a), {96'd0, rd}, 128'd0);
        end
        checkOutput("reset_start", {127'd0, AES_START}, 128'd0);
        checkOutput("reset_export", {96'd0, EXPORT_DATA}, 128'd0);
        checkOutput("reset_key", AES_KEY, 128'd0);

        $display("[TB] register table");
        for (int i = 0; i < 24; i++) begin
            if (vecs[i].wr) begin
                applyStimulus(vecs[i].addr, vecs[i].be, vecs[i].data);
            end else begin
                readReg(vecs[i].addr, rd, rds);
                checkOutput($sformatf("tbl%0d_rd%0d", i, vecs[i].addr), {96'd0, rd},
                            {96'd0, vecs[i].exp});
            end
            if (i == 7) begin
                checkOutput("key_full", AES_KEY, KEY_A);
                checkOutput("export", {96'd0, EXPORT_DATA}, 128'h2B7E4F3C);
                checkOutput("msg_enc", AES_MSG_ENC, CIPHER);
            end
        end
        checkOutput("no_start_be", {127'd0, AES_START}, 128'd0);

        @(negedge CLK);
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b1;
        AVL_ADDR = 4'd3; AVL_BYTE_EN = 4'hF; AVL_WRITEDATA = 32'h01020304;
        #1;
        checkOutput("rw_same_old", {96'd0, AVL_READDATA}, 128'h09CF4F3C);
        @(posedge CLK);
        #1;
        AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
        readReg(4'd3, rd, rds);
        checkOutput("rw_same_new", {96'd0, rd}, 128'h01020304);
        checkOutput("export_b", {96'd0, EXPORT_DATA}, 128'h2B7E0304);
        @(negedge CLK);
        AVL_CS = 1'b0; AVL_READ = 1'b1; AVL_ADDR = 4'd0;
        #1;
        checkOutput("rd_no_cs", {96'd0, AVL_READDATA}, 128'd0);
        AVL_READ = 1'b0;

        $display("[TB] handshake");
        applyStimulus(4'd14, 4'h1, 32'h1);
        checkOutput("start_rise", {127'd0, AES_START}, 128'd1);
        repeat (39) @(posedge CLK);
        @(negedge CLK);
        AES_DONE = 1'b1;
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = 4'd15;
        #1;
        checkOutput("done_before", {96'd0, AVL_READDATA}, 128'd0);
        AVL_CS = 1'b0; AVL_READ = 1'b0;
        @(posedge CLK);
        #1;
        checkOutput("start_hold", {127'd0, AES_START}, 128'd1);
        readReg(4'd15, rd, rds);
        checkOutput("done_after", {96'd0, rd}, 128'd1);
        readReg(4'd8, rd, rds);
        checkOutput("dec_w0", {96'd0, rd}, 128'h3243F6A8);
        readReg(4'd11, rd, rds);
        checkOutput("dec_w3", {96'd0, rd}, 128'hE0370734);
        readReg(4'd12, rd, rds);
        checkOutput("run_cycles", {96'd0, rd}, 128'd40);
        AES_MSG_DEC = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
        applyStimulus(4'd14, 4'h1, 32'h1);
        repeat (3) @(posedge CLK);
        readReg(4'd12, rd, rds);
        checkOutput("cycles_frozen", {96'd0, rd}, 128'd40);
        readReg(4'd8, rd, rds);
        checkOutput("dec_frozen", {96'd0, rd}, 128'h3243F6A8);
        readReg(4'd14, rd, rds);
        checkOutput("start_rd_done", {96'd0, rd}, 128'd1);
        applyStimulus(4'd14, 4'h1, 32'h0);
        AES_DONE = 1'b0;
        checkOutput("start_clear", {127'd0, AES_START}, 128'd0);
        readReg(4'd15, rd, rds);
        checkOutput("done_clear", {96'd0, rd}, 128'd0);
        readReg(4'd14, rd, rds);
        checkOutput("start_rd_clear", {96'd0, rd}, 128'd0);

        $display("[TB] writes ignored in run");
        applyStimulus(4'd14, 4'h1, 32'h1);
        applyStimulus(4'd0, 4'hF, 32'hDEADBEEF);
        applyStimulus(4'd9, 4'hF, 32'h12345678);
        readReg(4'd12, rd, rds);
        checkOutput("cycles_restart", {96'd0, rd}, 128'd2);
        checkOutput("key_locked", AES_KEY, KEY_B);
        readReg(4'd0, rd, rds);
        checkOutput("rd0_locked", {96'd0, rd}, 128'h2B7E1516);
        readReg(4'd9, rd, rds);
        checkOutput("rd9_locked", {96'd0, rd}, 128'h885A308D);

        $display("[TB] abort against done");
        @(negedge CLK);
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 4'd14;
        AVL_BYTE_EN = 4'h1; AVL_WRITEDATA = 32'h0;
        AES_DONE = 1'b1;
        @(posedge CLK);
        #1;
        AVL_CS = 1'b0; AVL_WRITE = 1'b0; AES_DONE = 1'b0;
        checkOutput("abort_start", {127'd0, AES_START}, 128'd0);
        readReg(4'd15, rd, rds);
        checkOutput("abort_done", {96'd0, rd}, 128'd0);
        readReg(4'd8, rd, rds);
        checkOutput("abort_dec", {96'd0, rd}, 128'h3243F6A8);

        $display("[TB] reset during run");
        applyStimulus(4'd14, 4'h1, 32'h1);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        AES_DONE = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("rst_start", {127'd0, AES_START}, 128'd0);
        @(negedge CLK);
        RESET = 1'b0;
        AES_DONE = 1'b0;
        checkOutput("rst_key", AES_KEY, 128'd0);
        checkOutput("rst_msg_enc", AES_MSG_ENC, 128'd0);
        checkOutput("rst_export", {96'd0, EXPORT_DATA}, 128'd0);
        for (int a = 0; a < 16; a++) begin
            readReg(a[3:0], rd, rds);
            checkOutput($sformatf("rst_rd%0d", a), {96'd0, rd}, 128'd0);
        end

        $display("[TB] counter saturation");
        applyStimulus(4'd14, 4'h1, 32'h1);
        repeat (20) @(posedge CLK);
        readReg(4'd12, rd, rds);
        checkOutput("cnt_wide_20", {96'd0, rd}, 128'd20);
        checkOutput("cnt_small_sat", {96'd0, rds}, 128'hF);
        repeat (5) @(posedge CLK);
        readReg(4'd12, rd, rds);
        checkOutput("cnt_wide_25", {96'd0, rd}, 128'd25);
        checkOutput("cnt_small_hold", {96'd0, rds}, 128'hF);
        checkOutput("small_start", {127'd0, small_start}, 128'd1);
        applyStimulus(4'd14, 4'h1, 32'h0);
        checkOutput("final_idle", {127'd0, AES_START}, 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
